// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet pipeline stages.
//   C1_OUT_W/H : C1 convolution output map size (S2 input)
//   S2_OUT_W/H : S2 pooled output map size
//   NCH        : feature-map channel count
//   DATA_W     : per-channel sample width (unsigned)
//   state_e    : frame-level control state shared by the streaming stages
package lenet_pkg;

  localparam int C1_OUT_W = 28;
  localparam int C1_OUT_H = 28;
  localparam int S2_OUT_W = C1_OUT_W / 2;
  localparam int S2_OUT_H = C1_OUT_H / 2;
  localparam int NCH      = 6;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/s2_row_buffer.sv
// Half-row buffer for the S2 max-pool stage. Holds one horizontal pair
// maximum per pooled column, all channels packed into one word.
//   clk     : rising-edge clock
//   wr_en   : write strobe, wr_data stored at wr_idx on the clock edge
//   wr_idx  : write entry index
//   wr_data : packed NCH x DATA_W word
//   rd_idx  : read entry index
//   rd_data : combinational read of entry rd_idx
module s2_row_buffer #(
  parameter int DEPTH = lenet_pkg::S2_OUT_W,
  parameter int WIDTH = lenet_pkg::NCH * lenet_pkg::DATA_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage arrays get no reset; every entry is written on an even
  // row before it is read on the following odd row, so old contents never
  // reach the output and a reset would only cost flops with reset pins.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/s2_maxpool.sv
// S2 subsampling stage: 2x2 stride-2 max pooling of the C1 raster stream.
//   clk, reset_n           : clock, asynchronous active-low reset
//   i_start                : pulse in IDLE arms a new frame
//   o_done                 : one-cycle pulse after the last pooled handshake
//   in_valid/in_ready      : upstream handshake (in_ready drives C1 i_conv_ready)
//   in_ch0..in_ch5         : one pixel position, all channels in parallel
//   out_valid/out_ready    : downstream handshake
//   out_ch0..out_ch5       : pooled samples
//   o_pool_row/o_pool_col  : pooled coordinates of the current output beat
module s2_maxpool #(
  parameter int IN_W   = lenet_pkg::C1_OUT_W,
  parameter int IN_H   = lenet_pkg::C1_OUT_H,
  parameter int DATA_W = lenet_pkg::DATA_W,
  parameter int NCH    = lenet_pkg::NCH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  output logic              o_done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_ch0,
  input  logic [DATA_W-1:0] in_ch1,
  input  logic [DATA_W-1:0] in_ch2,
  input  logic [DATA_W-1:0] in_ch3,
  input  logic [DATA_W-1:0] in_ch4,
  input  logic [DATA_W-1:0] in_ch5,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ch0,
  output logic [DATA_W-1:0] out_ch1,
  output logic [DATA_W-1:0] out_ch2,
  output logic [DATA_W-1:0] out_ch3,
  output logic [DATA_W-1:0] out_ch4,
  output logic [DATA_W-1:0] out_ch5,
  output logic [3:0]        o_pool_row,
  output logic [3:0]        o_pool_col
);

  import lenet_pkg::*;

  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);
  localparam int AW = $clog2(IN_W / 2);

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] pr_q [NCH];
  logic [DATA_W-1:0] pr_d [NCH];
  logic [DATA_W-1:0] out_q [NCH];
  logic [DATA_W-1:0] out_d [NCH];
  logic              out_valid_q, out_valid_d;
  logic [3:0]        pool_row_q, pool_row_d;
  logic [3:0]        pool_col_q, pool_col_d;

  logic [DATA_W-1:0]     in_data [NCH];
  logic [DATA_W-1:0]     buf_rd_ch [NCH];
  logic [NCH*DATA_W-1:0] buf_wr_data, buf_rd_data;
  logic                  accept, out_hs, last_hs, win_done, buf_wr_en;
  logic [AW-1:0]         buf_idx;

  assign in_data[0] = in_ch0;
  assign in_data[1] = in_ch1;
  assign in_data[2] = in_ch2;
  assign in_data[3] = in_ch3;
  assign in_data[4] = in_ch4;
  assign in_data[5] = in_ch5;

  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign last_hs   = out_hs && (pool_row_q == 4'(IN_H / 2 - 1))
                            && (pool_col_q == 4'(IN_W / 2 - 1));
  // Odd column completes a horizontal pair; odd row completes the window.
  assign win_done  = accept && col_q[0] && row_q[0];
  assign buf_wr_en = accept && col_q[0] && !row_q[0];
  assign buf_idx   = AW'(col_q >> 1);

  always_comb begin
    buf_wr_data = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      buf_wr_data[ch*DATA_W +: DATA_W] = umax(pr_q[ch], in_data[ch]);
      buf_rd_ch[ch] = buf_rd_data[ch*DATA_W +: DATA_W];
    end
  end

  s2_row_buffer #(
    .DEPTH (IN_W / 2),
    .WIDTH (NCH * DATA_W)
  ) u_row_buffer (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_idx  (buf_idx),
    .wr_data (buf_wr_data),
    .rd_idx  (buf_idx),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pr_d        = pr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pool_row_d  = pool_row_q;
    pool_col_d  = pool_col_q;

    unique case (state_q)
      IDLE: if (i_start) begin
        state_d = RUN;
        row_d   = '0;
        col_d   = '0;
      end
      RUN:     if (last_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // accept implies RUN, so this never collides with the IDLE clear.
    if (accept) begin
      if (col_q == CW'(IN_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IN_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (accept && !col_q[0]) pr_d = in_data;

    // A window completing on the handshake edge replaces the old beat.
    if (out_hs) out_valid_d = 1'b0;
    if (win_done) begin
      out_valid_d = 1'b1;
      pool_row_d  = 4'(row_q >> 1);
      pool_col_d  = 4'(col_q >> 1);
      for (int ch = 0; ch < NCH; ch++) begin
        out_d[ch] = umax(buf_rd_ch[ch], umax(pr_q[ch], in_data[ch]));
      end
    end
  end

  // NOTE: state elements use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pr_q        <= '{default: '0};
      out_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      pool_row_q  <= '0;
      pool_col_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pr_q        <= pr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pool_row_q  <= pool_row_d;
      pool_col_q  <= pool_col_d;
    end
  end

  assign o_done     = (state_q == DONE);
  assign out_valid  = out_valid_q;
  assign o_pool_row = pool_row_q;
  assign o_pool_col = pool_col_q;
  assign out_ch0    = out_q[0];
  assign out_ch1    = out_q[1];
  assign out_ch2    = out_q[2];
  assign out_ch3    = out_q[3];
  assign out_ch4    = out_q[4];
  assign out_ch5    = out_q[5];

endmodule

// File: tb/tb_s2_maxpool.sv
// Directed bench for s2_maxpool: ramp, hot pixel, backpressure, unsigned
// saturation, ignored start/idle beats and mid-frame reset.
module tb_s2_maxpool;

  import lenet_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic       o_done;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch0 = '0, in_ch1 = '0, in_ch2 = '0, in_ch3 = '0, in_ch4 = '0, in_ch5 = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_ch0, out_ch1, out_ch2, out_ch3, out_ch4, out_ch5;
  logic [3:0] o_pool_row, o_pool_col;

  int checks = 0;
  int failures = 0;

  localparam int NBEATS = C1_OUT_W * C1_OUT_H;
  localparam int NOUT   = S2_OUT_W * S2_OUT_H;

  always #5 clk = ~clk;

  s2_maxpool dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (i_start),
    .o_done     (o_done),
    .in_valid   (in_valid),
    .in_ch0     (in_ch0),
    .in_ch1     (in_ch1),
    .in_ch2     (in_ch2),
    .in_ch3     (in_ch3),
    .in_ch4     (in_ch4),
    .in_ch5     (in_ch5),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch0    (out_ch0),
    .out_ch1    (out_ch1),
    .out_ch2    (out_ch2),
    .out_ch3    (out_ch3),
    .out_ch4    (out_ch4),
    .out_ch5    (out_ch5),
    .o_pool_row (o_pool_row),
    .o_pool_col (o_pool_col)
  );

  // Stimulus patterns: 0 ramp, 1 hot pixel, 2 saturation.
  function automatic logic [7:0] in_pix(input int mode, input int r, input int c, input int k);
    case (mode)
      0:       return 8'((r + c + k) % 256);
      1:       return (r == 5 && c == 9 && k == 3) ? 8'hC8 : 8'h00;
      default: return (r <= 1 && c <= 1 && !(r == 1 && c == 1)) ? 8'h7F : 8'hFF;
    endcase
  endfunction

  // Hand-derived pooled results for each pattern.
  function automatic logic [7:0] exp_pix(input int mode, input int r, input int c, input int k);
    case (mode)
      0:       return 8'(2 * r + 2 * c + 2 + k);
      1:       return (r == 2 && c == 4 && k == 3) ? 8'hC8 : 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] get_out(input int k);
    case (k)
      0:       return out_ch0;
      1:       return out_ch1;
      2:       return out_ch2;
      3:       return out_ch3;
      4:       return out_ch4;
      default: return out_ch5;
    endcase
  endfunction

  task automatic drive_beat(input int mode, input int beat);
    int r = beat / C1_OUT_W;
    int c = beat % C1_OUT_W;
    in_ch0 = in_pix(mode, r, c, 0);
    in_ch1 = in_pix(mode, r, c, 1);
    in_ch2 = in_pix(mode, r, c, 2);
    in_ch3 = in_pix(mode, r, c, 3);
    in_ch4 = in_pix(mode, r, c, 4);
    in_ch5 = in_pix(mode, r, c, 5);
  endtask

  // Streams one full frame, checking every pooled beat as it handshakes.
  // stall: hold out_ready low 5 cycles when output (0,0) appears.
  // start_at: pulse i_start again when this beat index is presented (-1 = never).
  task automatic run_frame(input string name, input int mode, input bit stall, input int start_at);
    int beat = 0, n = 0, cyc = 0, done_cnt = 0, stall_left = 5;
    bit pulsed = 1'b0, held = 1'b0;
    logic [7:0] hold_d [6];
    logic [3:0] hold_r, hold_c;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    while (n < NOUT && cyc < 5000) begin
      if (beat < NBEATS) begin
        in_valid = 1'b1;
        drive_beat(mode, beat);
      end else begin
        in_valid = 1'b0;
      end
      i_start = 1'b0;
      if (start_at >= 0 && beat == start_at && !pulsed) begin
        i_start = 1'b1;
        pulsed  = 1'b1;
      end
      if (stall && n == 0 && out_valid && stall_left > 0) begin
        out_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (o_done) done_cnt++;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s stall_in_ready: got %b want 0", name, in_ready);
        end
        if (!held) begin
          for (int k = 0; k < 6; k++) hold_d[k] = get_out(k);
          hold_r = o_pool_row;
          hold_c = o_pool_col;
          held   = 1'b1;
        end else begin
          for (int k = 0; k < 6; k++) begin
            checks++;
            if (get_out(k) !== hold_d[k]) begin
              failures++;
              $display("FAIL %s stall_data ch%0d: got %h want %h", name, k, get_out(k), hold_d[k]);
            end
          end
          checks++;
          if (o_pool_row !== hold_r || o_pool_col !== hold_c || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s stall_coords: got (%0d,%0d) v=%b want (%0d,%0d) v=1",
                     name, o_pool_row, o_pool_col, out_valid, hold_r, hold_c);
          end
        end
      end
      if (in_valid && in_ready) beat++;
      if (out_valid && out_ready) begin
        checks++;
        if (o_pool_row !== 4'(n / S2_OUT_W) || o_pool_col !== 4'(n % S2_OUT_W)) begin
          failures++;
          $display("FAIL %s coords #%0d: got (%0d,%0d) want (%0d,%0d)",
                   name, n, o_pool_row, o_pool_col, n / S2_OUT_W, n % S2_OUT_W);
        end
        for (int k = 0; k < 6; k++) begin
          checks++;
          if (get_out(k) !== exp_pix(mode, n / S2_OUT_W, n % S2_OUT_W, k)) begin
            failures++;
            $display("FAIL %s data (%0d,%0d) ch%0d: got %h want %h", name,
                     n / S2_OUT_W, n % S2_OUT_W, k, get_out(k),
                     exp_pix(mode, n / S2_OUT_W, n % S2_OUT_W, k));
          end
        end
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    i_start   = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (n != NOUT || beat != NBEATS) begin
      failures++;
      $display("FAIL %s timeout: got outputs=%0d beats=%0d want %0d/%0d", name, n, beat, NOUT, NBEATS);
    end
    if (!stall) begin
      checks++;
      if (cyc > NBEATS + 6) begin
        failures++;
        $display("FAIL %s throughput: got %0d cycles want <= %0d", name, cyc, NBEATS + 6);
      end
    end
    #1;
    checks++;
    if (o_done !== 1'b1 || done_cnt != 0) begin
      failures++;
      $display("FAIL %s done_pulse: got o_done=%b early=%0d want 1/0", name, o_done, done_cnt);
    end
    @(negedge clk); #1;
    checks++;
    if (o_done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: got %b want 0", name, o_done);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (out_valid !== 1'b0 || o_done !== 1'b0 || in_ready !== 1'b0 ||
        o_pool_row !== 4'd0 || o_pool_col !== 4'd0) begin
      failures++;
      $display("FAIL %s ctrl: got v=%b done=%b rdy=%b r=%0d c=%0d want all 0",
               name, out_valid, o_done, in_ready, o_pool_row, o_pool_col);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (get_out(k) !== 8'h00) begin
        failures++;
        $display("FAIL %s out_ch%0d: got %h want 00", name, k, get_out(k));
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset_asserted");
    reset_n = 1'b1;
    @(negedge clk); #1;
    check_reset_values("reset_released");
  endtask

  task automatic test_ramp();
    run_frame("ramp", 0, 1'b0, -1);
  endtask

  task automatic test_hot_pixel();
    run_frame("hot_pixel", 1, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_frame("backpressure", 0, 1'b1, -1);
  endtask

  task automatic test_saturation();
    run_frame("saturation", 2, 1'b0, -1);
  endtask

  // Beats offered in IDLE must not be consumed; a start pulse mid-frame
  // must not disturb the counters (the frame would misalign otherwise).
  task automatic test_idle_and_restart();
    @(negedge clk);
    in_valid = 1'b1;
    in_ch0 = 8'hAA; in_ch1 = 8'hAA; in_ch2 = 8'hAA;
    in_ch3 = 8'hAA; in_ch4 = 8'hAA; in_ch5 = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_beat: got in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    run_frame("start_in_run", 0, 1'b0, 100);
  endtask

  task automatic test_reset_mid_frame();
    int beat = 0, cyc = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    while (beat < 300 && cyc < 2000) begin
      in_valid = 1'b1;
      drive_beat(0, beat);
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) beat++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (beat != 300) begin
      failures++;
      $display("FAIL mid_reset_prefix: got beats=%0d want 300", beat);
    end
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset_asserted");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    // in_valid is still high here; IDLE must refuse it.
    check_reset_values("mid_reset_released");
    @(negedge clk);
    in_valid = 1'b0;
    run_frame("after_reset", 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hot_pixel();
    test_backpressure();
    test_saturation();
    test_idle_and_restart();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
